// File: rtl/delay_timer.sv
// Prescaled delay timer for the program counter's delay handshake.
// Times delay_val ticks of TICK_DIV clocks, then raises count_done until the PC may advance.
module delay_timer #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          delay,
  input  logic [DW-1:0] delay_val,
  input  logic          pchalt,
  output logic          count_done,
  output logic          busy,
  output logic [DW-1:0] remaining
);

  localparam int unsigned   PW         = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] w_rem_nxt;
  logic          r_count_done;
  logic          r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_rem_nxt   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (delay) begin
          if (delay_val == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_rem_nxt   = delay_val;
            w_pre_nxt   = PRE_RELOAD;
            w_state_nxt = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (!delay) begin
          w_state_nxt = S_IDLE;
          w_rem_nxt   = '0;
        end else if (!pchalt) begin
          if (r_pre != '0) begin
            w_pre_nxt = r_pre - 1'b1;
          end else begin
            // One tick elapsed; the decrement is gated so remaining cannot wrap.
            w_pre_nxt = PRE_RELOAD;
            if (r_rem != '0) begin
              w_rem_nxt = r_rem - 1'b1;
            end
            if (r_rem <= DW'(1)) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (!delay || !pchalt) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_count_done <= (w_state_nxt == S_DONE);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign count_done = r_count_done;
  assign busy       = r_busy;
  assign remaining  = r_rem;

endmodule
